// File: rtl/serial_addsub_lanes.sv
// rtl/serial_addsub_lanes.sv - multi-lane bit-serial two's-complement add/sub, LSB first (option: OVERFLOW_DETECT_EN)
`timescale 1ns/1ps
module serial_addsub_lanes #(
    parameter int LANES  = 4,
    parameter int WORD_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             start,
    input  logic             sub,
    input  logic [LANES-1:0] x,
    input  logic [LANES-1:0] y,
    output logic [LANES-1:0] sum,
    output logic             out_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy,
    output logic [LANES-1:0] carry_out,
    output logic [LANES-1:0] ovf
);
    localparam int CW = $clog2(WORD_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [LANES-1:0] c;
    logic             mode;

    logic             accept;
    logic             bit0;
    logic             at_msb;
    logic             mode_eff;
    logic [LANES-1:0] c_eff;
    logic [LANES-1:0] yb;
    logic [LANES-1:0] s;
    logic [LANES-1:0] cn;

    // Bit 0 takes its mode and carry-in straight from the inputs so back-to-back words need no bubble.
    always_comb begin
        accept   = in_valid && ((state == RUN) || start);
        bit0     = (state == IDLE);
        at_msb   = !bit0 && (cnt == CW'(WORD_W - 1));
        mode_eff = bit0 ? sub : mode;
        c_eff    = bit0 ? {LANES{sub}} : c;
        yb       = y ^ {LANES{mode_eff}};
        s        = x ^ yb ^ c_eff;
        cn       = (x & yb) | (x & c_eff) | (yb & c_eff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            c         <= '0;
            mode      <= 1'b0;
            sum       <= '0;
            out_valid <= 1'b0;
            first_bit <= 1'b0;
            last_bit  <= 1'b0;
            busy      <= 1'b0;
            carry_out <= '0;
        end else begin
            out_valid <= accept;
            first_bit <= accept && bit0;
            last_bit  <= accept && at_msb;
            if (accept) begin
                sum <= s;
                c   <= cn;
                if (bit0) begin
                    mode  <= sub;
                    state <= RUN;
                    busy  <= 1'b1;
                    cnt   <= CW'(1);
                end else if (at_msb) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cnt       <= '0;
                    carry_out <= cn;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

`ifdef OVERFLOW_DETECT_EN
    // On the MSB cycle the per-lane carry register c holds exactly the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= '0;
        end else if (accept && at_msb) begin
            ovf <= c ^ cn;
        end
    end
`else
    assign ovf = '0;
`endif

endmodule

// File: tb/tb_serial_addsub_lanes.sv
// tb/tb_serial_addsub_lanes.sv - directed table-driven bench for serial_addsub_lanes (LANES=2, WORD_W=8)
`timescale 1ns/1ps
module tb_serial_addsub_lanes;
    localparam int LANES  = 2;
    localparam int WORD_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             start;
    logic             sub;
    logic [LANES-1:0] x;
    logic [LANES-1:0] y;
    logic [LANES-1:0] sum;
    logic             out_valid;
    logic             first_bit;
    logic             last_bit;
    logic             busy;
    logic [LANES-1:0] carry_out;
    logic [LANES-1:0] ovf;

    serial_addsub_lanes #(.LANES(LANES), .WORD_W(WORD_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .start(start), .sub(sub),
        .x(x), .y(y), .sum(sum), .out_valid(out_valid), .first_bit(first_bit),
        .last_bit(last_bit), .busy(busy), .carry_out(carry_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x0, x1, y0, y1;
        logic       s;
        logic [7:0] e0, e1;
        logic [1:0] eco, eov;
    } vec_t;

    typedef struct {
        logic [7:0] s0, s1;
        logic [1:0] co, ov;
        bit         frame_ok, hold_ok;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   nvalid = 0;
    int   nfirst = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    res_t rq[$];

    int         idx = 0;
    logic [7:0] a0, a1;
    logic [1:0] co_prev;
    bit         frame_ok, hold_ok;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (first_bit) begin
                idx = 0; frame_ok = 1; hold_ok = 1; co_prev = carry_out; nfirst++;
            end else begin
                idx++;
            end
            if (idx < 8) begin
                a0[idx] = sum[0];
                a1[idx] = sum[1];
            end
            if (!last_bit && carry_out !== co_prev) hold_ok = 0;
            if (last_bit != (idx == 7)) frame_ok = 0;
            nvalid++;
            if (nvalid == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (last_bit) rq.push_back('{a0, a1, carry_out, ovf, frame_ok, hold_ok});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_ov(input logic [1:0] v);
`ifdef OVERFLOW_DETECT_EN
        return v;
`else
        return 2'b00 & v;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        start    = 0;
        repeat (n) tick();
    endtask

    // sub is inverted after bit 0 to show it only matters when start is accepted
    task automatic drive_word(input vec_t v, input int stall_at, input int stall_n);
        for (int b = 0; b < 8; b++) begin
            if (b == stall_at) begin
                for (int k = 0; k < stall_n; k++) begin
                    in_valid = 0;
                    start    = 0;
                    tick();
                    chk("stall_busy", busy, 1);
                    chk("stall_out_valid", out_valid, 0);
                end
            end
            in_valid = 1;
            start    = (b == 0);
            sub      = (b == 0) ? v.s : ~v.s;
            x        = {v.x1[b], v.x0[b]};
            y        = {v.y1[b], v.y0[b]};
            tick();
        end
    endtask

    task automatic check_word(input string name, input vec_t v);
        res_t r;
        checks++;
        if (rq.size() == 0) begin
            errors++;
            $display("FAIL %s_present: got 0 words expected 1", name);
        end else begin
            r = rq.pop_front();
            chk({name, "_sum0"}, r.s0, v.e0);
            chk({name, "_sum1"}, r.s1, v.e1);
            chk({name, "_carry"}, r.co, v.eco);
            chk({name, "_ovf"}, r.ov, exp_ov(v.eov));
            chk({name, "_frame"}, r.frame_ok, 1);
            chk({name, "_carry_hold"}, r.hold_ok, 1);
        end
    endtask

    vec_t tbl[5];
    vec_t v_sub2;
    vec_t v_one;
    int   nf;

    initial begin
        tbl[0] = '{8'h05, 8'hFF, 8'h03, 8'h01, 1'b0, 8'h08, 8'h00, 2'b10, 2'b00};
        tbl[1] = '{8'h7F, 8'h10, 8'hFF, 8'h20, 1'b1, 8'h80, 8'hF0, 2'b00, 2'b01};
        tbl[2] = '{8'h7F, 8'h80, 8'h01, 8'h80, 1'b0, 8'h80, 8'h00, 2'b10, 2'b11};
        tbl[3] = '{8'h00, 8'h05, 8'h01, 8'h05, 1'b1, 8'hFF, 8'h00, 2'b10, 2'b00};
        tbl[4] = '{8'h80, 8'h01, 8'h01, 8'h80, 1'b1, 8'h7F, 8'h81, 2'b01, 2'b11};
        v_sub2 = '{8'h7F, 8'h05, 8'hFF, 8'h05, 1'b1, 8'h80, 8'h00, 2'b10, 2'b01};
        v_one  = '{8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 8'h02, 8'h02, 2'b00, 2'b00};

        rst = 1; in_valid = 0; start = 0; sub = 0; x = '0; y = '0;
        tick(); tick();
        rst = 0;
        tick();
        chk("reset_outputs", {sum, out_valid, first_bit, last_bit, busy, carry_out, ovf}, 0);

        for (int i = 0; i < 5; i++) begin
            drive_word(tbl[i], -1, 0);
            idle(2);
            check_word($sformatf("vec%0d", i), tbl[i]);
        end

        // Stall of 3 cycles before bit 4: 8 outputs spread over 11 cycles
        nvalid = 0;
        drive_word(tbl[0], 4, 3);
        idle(2);
        chk("stall_count", nvalid, 8);
        chk("stall_span", last_cyc - first_cyc, 10);
        check_word("stall", tbl[0]);

        // Back-to-back add then subtract: 16 consecutive output cycles
        nvalid = 0;
        drive_word(tbl[0], -1, 0);
        drive_word(v_sub2, -1, 0);
        idle(2);
        chk("b2b_count", nvalid, 16);
        chk("b2b_span", last_cyc - first_cyc, 15);
        check_word("b2b_add", tbl[0]);
        check_word("b2b_sub", v_sub2);

        // Reset during bit 4, with start held high while busy
        nf = nfirst;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1; start = 1; sub = 0;
            x = {v_one.x1[b], v_one.x0[b]};
            y = {v_one.y1[b], v_one.y0[b]};
            tick();
        end
        chk("busy_start_ignored", nfirst - nf, 1);
        chk("busy_mid_word", busy, 1);
        x = 2'b00; y = 2'b00;
        #2;
        rst = 1;
        #1;
        chk("async_reset_outputs", {sum, out_valid, first_bit, last_bit, busy, carry_out, ovf}, 0);
        tick();
        in_valid = 0; start = 0;
        rst = 0;
        tick();
        chk("post_reset_idle", {out_valid, busy}, 0);
        drive_word(v_one, -1, 0);
        idle(2);
        check_word("after_reset", v_one);
        chk("no_extra_words", rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
